alu_bit_serial_ctrl: RTL
========================

Name: alu_bit_serial_ctrl

Overview:
Controller that runs a full WIDTH-bit ALU operation on the existing single 1-bit ALU slice. It shifts operands through the slice one bit per clock, LSB first, and chains the carry through a register. It assembles the result, flags and set-less-than outcome, and reports completion on a start/done handshake. Sits between the CPU control unit (issues Start/OpSel) and one external 1-bit ALU slice instance.

Parameters:
WIDTH, 16, operand/result width in bits (≥2)
CNT_W, 4, bit-index counter width, ceil(log2(WIDTH))

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  request; sampled only in IDLE
OpSel  in  3  000 AND, 010 OR, 011 XOR, 100 ADD, 101 SUB, 110 SLT; 001/111 illegal
A  in  WIDTH  operand A, captured at accepted Start
B  in  WIDTH  operand B, captured at accepted Start
Busy  out  1  high in RUN and DONE
Done  out  1  one-cycle completion pulse
Result  out  WIDTH  final result, held until next accepted Start
CarryOut  out  1  MSB carry-out (ADD/SUB/SLT), else 0
Overflow  out  1  signed overflow (ADD/SUB/SLT), else 0
Zero  out  1  Result == 0
Illegal  out  1  last op was 001/111
SliceA, SliceB, SliceCIN, SliceBInvert, SliceLess  out  1 each  drive slice inputs
SliceOperation  out  3  slice op: 000 AND, 010 OR, 011 XOR, 100 ADD
SliceResult, SliceCOUT  in  1 each  slice outputs

Behaviour:
- Reset (async, any state): state=IDLE; Busy, Done, Result, CarryOut, Overflow, Zero, Illegal, counter, shift and carry registers all 0. Slice drive outputs are 0.
- States: IDLE -> RUN on Start; RUN -> DONE when bit index == WIDTH-1 at the clock edge; DONE -> IDLE unconditionally.
- Start in RUN/DONE ignored: no queueing, no effect on the running op. Start and OpSel are don't-care outside IDLE.
- On accept: latch A, B into shift regs and OpSel into op reg; index=0.
- Carry reg init: 1 for SUB/SLT, else 0. Clear Illegal and Result.
- RUN, combinational slice drive:
  - SliceA/SliceB = LSB of shift regs; SliceCIN = carry reg; SliceLess = 0.
  - ADD: SliceOperation=100, SliceBInvert=0. SUB/SLT: SliceOperation=100, SliceBInvert=1.
  - Logic ops: SliceOperation = OpSel, SliceBInvert=0, SliceCIN forced 0.
- RUN, each edge: shift A/B right; shift SliceResult into result reg MSB; carry reg <= SliceCOUT; index++.
  - At index WIDTH-1 also capture msb_cin=SliceCIN, msb_cout=SliceCOUT, msb_res=SliceResult.
- DONE (exactly one cycle): Done=1, Busy=1.
  - Result: assembled word. For SLT: {WIDTH-1 zeros, msb_res ^ (msb_cin ^ msb_cout)}.
  - CarryOut=msb_cout and Overflow=msb_cin^msb_cout for arithmetic ops, else 0. Zero computed from final Result.
- Illegal op: accepted, sequencing identical. Slice driven as AND with SliceA/SliceB gated to 0. Result=0, Zero=1, Illegal=1.
- Flags/Result update on DONE entry and hold in IDLE.
- Latency: Start sampled at edge N; Done high during the cycle after edge N+WIDTH (WIDTH+1 cycles). Throughput: one op per WIDTH+2 cycles.
- Reset mid-RUN: op aborted, no Done pulse, outputs return to reset values.

Decomposition:
- Package alu_serial_pkg: OpSel codes, slice Operation codes (AND/OR/XOR/ADD), state enum (IDLE/RUN/DONE).
- Single module, no sub-modules. The 1-bit slice stays external and is wired beside the controller at CPU top and in the bench.

Test Plan:
- ADD 0x7FFF+0x0001 -> Result 0x8000, Overflow 1, CarryOut 0, Zero 0; Done exactly 17 cycles after Start edge.
- SUB 0x0005-0x0005 -> Result 0x0000, Zero 1, CarryOut 1, Overflow 0. SUB 0x0003-0x0005 -> 0xFFFE, CarryOut 0.
- SLT 0xFFFF vs 0x0001 -> Result 0x0001. SLT 0x8000 vs 0x7FFF -> 0x0001 (overflow path, Overflow 1). SLT 0x0001 vs 0xFFFF -> 0x0000.
- XOR 0xA5A5^0xFFFF -> 0x5A5A; OR 0x00F0|0x0F00 -> 0x0FF0; AND 0xF0F0&0xFF00 -> 0xF000; CarryOut/Overflow 0.
- Start ADD, then Start SUB with new operands at cycle 5 -> ignored; Result is ADD value, single Done pulse. Illegal OpSel 111 -> Illegal 1, Result 0, Zero 1.
- Reset asserted mid-RUN (bit index 7) -> immediately IDLE, Busy 0, Result 0, no Done. Next Start ADD 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared codes for the bit-serial ALU controller: OpSel encodings,
// 1-bit slice operation codes, controller state enum and op helpers.
package alu_serial_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    localparam logic [2:0] SL_AND = 3'b000;
    localparam logic [2:0] SL_OR  = 3'b010;
    localparam logic [2:0] SL_XOR = 3'b011;
    localparam logic [2:0] SL_ADD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return (op != 3'b001) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/alu_bit_serial_ctrl.sv
// Bit-serial ALU controller: streams WIDTH-bit operands LSB first through
// an external 1-bit ALU slice, chaining carry through a register.
// Ports: clk, rst (async, active-high); start/opsel/a/b request;
// busy/done handshake; result/carryout/overflow/zero/illegal outputs;
// slice_* drive the slice, slice_result/slice_cout come back from it.
module alu_bit_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_binvert,
    output logic             slice_less,
    output logic [2:0]       slice_operation,
    input  logic             slice_result,
    input  logic             slice_cout
);

    state_e state, state_nx;

    logic [WIDTH-1:0] sh_a, sh_b;
    // Bits already produced; the bit from the slice this cycle completes the word.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] fin_res;
    logic [2:0]       op;
    logic             carry;
    logic [CNT_W-1:0] idx;
    logic             last;
    logic             msb_v;

    assign last   = (idx == CNT_W'(WIDTH - 1));
    assign res_nx = {slice_result, res_sh};
    assign msb_v  = slice_cin ^ slice_cout;
    assign slice_less = 1'b0;

    always_comb begin
        fin_res = res_nx;
        if (!is_legal(op))
            fin_res = '0;
        else if (op == OP_SLT)
            fin_res = {{(WIDTH-1){1'b0}}, slice_result ^ msb_v};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        busy            = 1'b0;
        done            = 1'b0;
        slice_a         = 1'b0;
        slice_b         = 1'b0;
        slice_cin       = 1'b0;
        slice_binvert   = 1'b0;
        slice_operation = SL_AND;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                slice_a   = sh_a[0];
                slice_b   = sh_b[0];
                slice_cin = carry;
                if (last)
                    state_nx = DONE;
                case (op)
                    OP_ADD: slice_operation = SL_ADD;
                    OP_SUB, OP_SLT: begin
                        slice_operation = SL_ADD;
                        slice_binvert   = 1'b1;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        slice_operation = op;
                        slice_cin       = 1'b0;
                    end
                    default: begin
                        // Illegal op: run the sequence on a dead AND slice.
                        slice_operation = SL_AND;
                        slice_a         = 1'b0;
                        slice_b         = 1'b0;
                        slice_cin       = 1'b0;
                    end
                endcase
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            res_sh   <= '0;
            op       <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a    <= a;
                        sh_b    <= b;
                        op      <= opsel;
                        idx     <= '0;
                        res_sh  <= '0;
                        // Subtraction is A + ~B + 1: seed the carry chain.
                        carry   <= (opsel == OP_SUB) || (opsel == OP_SLT);
                        result  <= '0;
                        illegal <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    res_sh <= res_nx[WIDTH-1:1];
                    carry  <= slice_cout;
                    idx    <= idx + CNT_W'(1);
                    if (last) begin
                        result   <= fin_res;
                        carryout <= is_arith(op) & slice_cout;
                        overflow <= is_arith(op) & msb_v;
                        zero     <= (fin_res == '0);
                        illegal  <= !is_legal(op);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
